// File: rtl/pipe_fetch.sv
// Instruction-fetch stage with IF/ID register, one-entry holding buffer for
// decode stalls and a redirect latch for branches that leave decode during a fetch wait.
module pipe_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        wpcir,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] dinst,
    output logic [31:0] dpc4,
    output logic        dvalid
);

    logic        hvalid;
    logic [31:0] hinst;
    logic        pend;
    logic [31:0] ptgt;

    logic        have;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic [31:0] sel;
    logic [31:0] npc;

    assign have      = hvalid | imem_ready;
    assign inst      = hvalid ? hinst : imem_rdata;
    assign pc4       = pc + 32'd4;
    assign imem_req  = ~reset & ~hvalid;
    assign imem_addr = pc;

    always_comb begin
        sel = pc4;
        case (pcsource)
            2'b01:   sel = bpc;
            2'b10:   sel = rpc;
            2'b11:   sel = jpc;
            default: sel = pc4;
        endcase
    end

    // A latched redirect wins over whatever decode presents now.
    assign npc = pend ? ptgt : sel;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            dinst  <= 32'd0;
            dpc4   <= 32'd0;
            dvalid <= 1'b0;
            hvalid <= 1'b0;
            hinst  <= 32'd0;
            pend   <= 1'b0;
            ptgt   <= 32'd0;
        end else if (wpcir && have) begin
            dinst  <= inst;
            dpc4   <= pc4;
            dvalid <= 1'b1;
            pc     <= npc;
            hvalid <= 1'b0;
            pend   <= 1'b0;
        end else if (wpcir) begin
            dinst  <= 32'd0;
            dvalid <= 1'b0;
            // The branch leaves decode before its delay slot arrives; remember where to go.
            if (!pend && pcsource != 2'b00) begin
                pend <= 1'b1;
                ptgt <= sel;
            end
        end else begin
            if (imem_ready && !hvalid) begin
                hinst  <= imem_rdata;
                hvalid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_fetch.sv
// Randomized bench for pipe_fetch, checked against a queue-based behavioural model
// of the fetch stage (buffered instruction and pending redirect kept as queues).
module tb_pipe_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'd0;
    logic [31:0] rpc = 32'd0;
    logic [31:0] jpc = 32'd0;
    logic        wpcir = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] dinst;
    logic [31:0] dpc4;
    logic        dvalid;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_dinst;
    logic [31:0] m_dpc4;
    logic        m_dvalid;
    logic [31:0] m_buf[$];
    logic [31:0] m_redir[$];

    pipe_fetch #(.RESET_PC(RESET_PC)) dut (
        .clock(clock),
        .reset(reset),
        .pcsource(pcsource),
        .bpc(bpc),
        .rpc(rpc),
        .jpc(jpc),
        .wpcir(wpcir),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .pc(pc),
        .dinst(dinst),
        .dpc4(dpc4),
        .dvalid(dvalid)
    );

    always #5 clock = ~clock;

    // Instruction memory contents are a fixed function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA000_0000;
    endfunction

    assign imem_rdata = memf(imem_addr);

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = RESET_PC;
        m_dinst  = 32'd0;
        m_dpc4   = 32'd0;
        m_dvalid = 1'b0;
        m_buf.delete();
        m_redir.delete();
    endtask

    task automatic check_state();
        checkOutput("pc", pc, m_pc);
        checkOutput("dinst", dinst, m_dinst);
        checkOutput("dpc4", dpc4, m_dpc4);
        checkOutput("dvalid", 32'(dvalid), 32'(m_dvalid));
    endtask

    // One clock cycle: drive inputs, check fetch-side outputs, step the model, check IF/ID.
    task automatic applyStimulus(input logic w, input logic r, input logic [1:0] ps,
                                 input logic [31:0] b, input logic [31:0] rr, input logic [31:0] j);
        logic [31:0] tgt;
        logic [31:0] ins;
        bit          hv;
        wpcir      = w;
        imem_ready = r;
        pcsource   = ps;
        bpc        = b;
        rpc        = rr;
        jpc        = j;
        #1;
        checkOutput("imem_req", 32'(imem_req), (m_buf.size() == 0) ? 32'd1 : 32'd0);
        checkOutput("imem_addr", imem_addr, m_pc);
        case (ps)
            2'b00: tgt = m_pc + 32'd4;
            2'b01: tgt = b;
            2'b10: tgt = rr;
            default: tgt = j;
        endcase
        hv  = (m_buf.size() > 0) || r;
        ins = (m_buf.size() > 0) ? m_buf[0] : memf(m_pc);
        if (w && hv) begin
            m_dinst  = ins;
            m_dpc4   = m_pc + 32'd4;
            m_dvalid = 1'b1;
            m_pc     = (m_redir.size() > 0) ? m_redir[0] : tgt;
            m_buf.delete();
            m_redir.delete();
        end else if (w) begin
            m_dinst  = 32'd0;
            m_dvalid = 1'b0;
            if (m_redir.size() == 0 && ps != 2'b00) m_redir.push_back(tgt);
        end else if (r && m_buf.size() == 0) begin
            m_buf.push_back(memf(m_pc));
        end
        @(posedge clock);
        #1;
        check_state();
    endtask

    // Asynchronous reset asserted between edges, held across one edge, released mid-cycle.
    task automatic reset_pulse();
        #3 reset = 1'b1;
        #1;
        checkOutput("rst_pc", pc, RESET_PC);
        checkOutput("rst_dvalid", 32'(dvalid), 32'd0);
        checkOutput("rst_dinst", dinst, 32'd0);
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        @(posedge clock);
        #3 reset = 1'b0;
        model_reset();
        #1;
        check_state();
    endtask

    initial begin
        logic [31:0] t;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_req_init", 32'(imem_req), 32'd0);
        check_state();
        #3 reset = 1'b0;
        #1;
        check_state();

        // Sequential fetch, then two wait states at pc=0xC.
        repeat (3) applyStimulus(1, 1, 2'b00, 0, 0, 0);
        repeat (2) applyStimulus(1, 0, 2'b00, 0, 0, 0);
        applyStimulus(1, 1, 2'b00, 0, 0, 0);
        // Decode stall overlapping a completed fetch.
        repeat (3) applyStimulus(0, 1, 2'b00, 0, 0, 0);
        applyStimulus(1, 0, 2'b00, 0, 0, 0);
        // Branch with delay slot, jr, and a jump to the top of memory to wrap PC.
        applyStimulus(1, 1, 2'b01, 32'h100, 0, 0);
        repeat (2) applyStimulus(1, 1, 2'b00, 0, 0, 0);
        applyStimulus(1, 1, 2'b10, 0, 32'h180, 0);
        applyStimulus(1, 1, 2'b11, 0, 0, 32'hFFFF_FFFC);
        repeat (2) applyStimulus(1, 1, 2'b00, 0, 0, 0);
        // Redirect during a wait, later nonzero pcsource ignored while pending.
        applyStimulus(1, 0, 2'b11, 0, 0, 32'h200);
        applyStimulus(1, 0, 2'b01, 32'h300, 0, 0);
        applyStimulus(1, 0, 2'b00, 0, 0, 0);
        repeat (3) applyStimulus(1, 1, 2'b00, 0, 0, 0);
        // Build pend=1 and hvalid=1, then reset.
        applyStimulus(1, 0, 2'b11, 0, 0, 32'h400);
        applyStimulus(0, 1, 2'b00, 0, 0, 0);
        reset_pulse();
        repeat (2) applyStimulus(1, 1, 2'b00, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) == 0) begin
                reset_pulse();
            end else begin
                t = ($urandom_range(9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
                applyStimulus(($urandom_range(3) != 0), ($urandom_range(2) != 0),
                              ($urandom_range(4) == 0) ? 2'($urandom_range(3)) : 2'b00,
                              t, t ^ 32'h0000_0040, t ^ 32'h0000_0080);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
